// File: rtl/worksheet_pkg.sv
// Shared types and constants for the worksheet solver.
// Optional overflow flag is enabled by defining WORKSHEET_OVERFLOW_EN.
package worksheet_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_IN,
        TERM,
        COMMIT,
        DONE
    } state_t;

    typedef enum logic {
        OP_MUL = 1'b0,
        OP_ADD = 1'b1
    } op_t;

    typedef enum logic {
        MODE_ROW = 1'b0,
        MODE_COL = 1'b1
    } mode_t;

    // Nibbles above this value are blanks.
    localparam logic [3:0] BCD_MAX = 4'd9;

    function automatic int max_of(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/worksheet_if.sv
// Worksheet solver control, problem handshake and result bundle.
// The overflow signal exists only when WORKSHEET_OVERFLOW_EN is defined.
interface worksheet_if #(
    parameter int NUM_ROWS = 4,
    parameter int DIGITS   = 4,
    parameter int RES_W    = 64
);

    logic                         start;
    logic                         mode;
    logic                         in_valid;
    logic                         in_ready;
    logic [NUM_ROWS*DIGITS*4-1:0] in_digits;
    logic                         in_op;
    logic                         in_last;
    logic                         busy;
    logic                         done;
    logic [RES_W-1:0]             result;
`ifdef WORKSHEET_OVERFLOW_EN
    logic                         overflow;
`endif

`ifdef WORKSHEET_OVERFLOW_EN
    modport master (
        output start, mode, in_valid, in_digits, in_op, in_last,
        input  in_ready, busy, done, result, overflow
    );
    modport slave (
        input  start, mode, in_valid, in_digits, in_op, in_last,
        output in_ready, busy, done, result, overflow
    );
`else
    modport master (
        output start, mode, in_valid, in_digits, in_op, in_last,
        input  in_ready, busy, done, result
    );
    modport slave (
        input  start, mode, in_valid, in_digits, in_op, in_last,
        output in_ready, busy, done, result
    );
`endif

endinterface

// File: rtl/worksheet_term_build.sv
// Combinational BCD-to-binary term builder (Horner x10 chain).
// Nibble 0 is read first (most significant); blank nibbles are skipped.
module worksheet_term_build
    import worksheet_pkg::*;
#(
    parameter int N = 4,
    parameter int W = 64
) (
    input  logic [N*4-1:0] i_nibs,
    output logic [W-1:0]   o_term,
    output logic           o_nonblank
);

    logic [W-1:0] w_acc;
    logic         w_nb;
    logic [3:0]   w_nib;

    // Fold the digits left to right, ignoring blanks.
    always_comb begin
        w_acc = '0;
        w_nb  = 1'b0;
        w_nib = '0;
        for (int i = 0; i < N; i++) begin
            w_nib = i_nibs[i*4 +: 4];
            if (w_nib <= BCD_MAX) begin
                w_acc = (w_acc * W'(10)) + W'(w_nib);
                w_nb  = 1'b1;
            end
        end
    end

    assign o_term     = w_acc;
    assign o_nonblank = w_nb;

endmodule

// File: rtl/worksheet_solver.sv
// Worksheet solver: evaluates problems term by term and sums them.
// Define WORKSHEET_OVERFLOW_EN to add the sticky overflow output.
module worksheet_solver
    import worksheet_pkg::*;
#(
    parameter int NUM_ROWS = 4,
    parameter int DIGITS   = 4,
    parameter int RES_W    = 64
) (
    input  logic        clk,
    input  logic        rst,
    worksheet_if.slave  bus
);

    localparam int NMAX = max_of(NUM_ROWS, DIGITS);
    localparam int CW   = $clog2(NMAX) + 1;

    state_t                             r_state;
    state_t                             w_next;
    mode_t                              r_mode;
    op_t                                r_op;
    logic                               r_last;
    logic                               r_any;
    logic [NUM_ROWS-1:0][DIGITS-1:0][3:0] r_digits;
    logic [CW-1:0]                      r_cnt;
    logic [RES_W-1:0]                   r_pv;
    logic [RES_W-1:0]                   r_acc;

    logic                               w_ld_start;
    logic                               w_take;
    logic                               w_step;
    logic                               w_commit;
    logic [CW-1:0]                      w_nt;
    logic                               w_last_term;
    logic [NMAX-1:0][3:0]               w_nibs;
    logic [RES_W-1:0]                   w_term;
    logic                               w_nonblank;
    logic [RES_W-1:0]                   w_contrib;
    logic [RES_W-1:0]                   w_pv_next;
    logic [RES_W-1:0]                   w_acc_next;

    assign w_nt = (r_mode == MODE_COL) ? CW'(DIGITS) : CW'(NUM_ROWS);
    assign w_last_term = (r_cnt == (w_nt - CW'(1)));
    // A problem with only blank terms adds nothing, even for multiply.
    assign w_contrib = r_any ? r_pv : '0;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic and datapath strobes.
    always_comb begin
        w_next     = r_state;
        w_ld_start = 1'b0;
        w_take     = 1'b0;
        w_step     = 1'b0;
        w_commit   = 1'b0;
        unique case (r_state)
            IDLE, DONE: begin
                if (bus.start) begin
                    w_ld_start = 1'b1;
                    w_next     = WAIT_IN;
                end
            end
            WAIT_IN: begin
                if (bus.in_valid) begin
                    w_take = 1'b1;
                    w_next = TERM;
                end
            end
            TERM: begin
                w_step = 1'b1;
                if (w_last_term) begin
                    w_next = COMMIT;
                end
            end
            COMMIT: begin
                w_commit = 1'b1;
                w_next   = r_last ? DONE : WAIT_IN;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // Select the nibbles of the current term, most significant first.
    always_comb begin
        w_nibs = '1;
        for (int k = 0; k < NUM_ROWS; k++) begin
            if (r_mode == MODE_ROW && r_cnt == CW'(k)) begin
                for (int d = 0; d < DIGITS; d++) begin
                    w_nibs[DIGITS-1-d] = r_digits[k][d];
                end
            end
        end
        for (int k = 0; k < DIGITS; k++) begin
            if (r_mode == MODE_COL && r_cnt == CW'(k)) begin
                for (int r = 0; r < NUM_ROWS; r++) begin
                    w_nibs[r] = r_digits[r][k];
                end
            end
        end
    end

    worksheet_term_build #(
        .N (NMAX),
        .W (RES_W)
    ) u_term (
        .i_nibs     (w_nibs),
        .o_term     (w_term),
        .o_nonblank (w_nonblank)
    );

`ifdef WORKSHEET_OVERFLOW_EN
    logic [2*RES_W-1:0] w_prod;
    logic [RES_W:0]     w_sum;
    logic [RES_W:0]     w_accs;
    logic               w_ovf_term;
    logic               w_ovf_acc;
    logic               r_ovf;

    assign w_prod = {{RES_W{1'b0}}, r_pv} * {{RES_W{1'b0}}, w_term};
    assign w_sum  = {1'b0, r_pv} + {1'b0, w_term};
    assign w_accs = {1'b0, r_acc} + {1'b0, w_contrib};
    assign w_pv_next = (r_op == OP_ADD) ? w_sum[RES_W-1:0]
                                        : w_prod[RES_W-1:0];
    assign w_ovf_term = (r_op == OP_ADD) ? w_sum[RES_W]
                                         : (|w_prod[2*RES_W-1:RES_W]);
    assign w_acc_next = w_accs[RES_W-1:0];
    assign w_ovf_acc  = w_accs[RES_W];

    // Sticky overflow, cleared when a new worksheet starts.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ovf <= 1'b0;
        end else if (w_ld_start) begin
            r_ovf <= 1'b0;
        end else if ((w_step && w_nonblank && w_ovf_term) ||
                     (w_commit && w_ovf_acc)) begin
            r_ovf <= 1'b1;
        end
    end

    assign bus.overflow = r_ovf;
`else
    assign w_pv_next  = (r_op == OP_ADD) ? (r_pv + w_term)
                                         : (r_pv * w_term);
    assign w_acc_next = r_acc + w_contrib;
`endif

    // Problem capture, per-term update and accumulation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mode   <= MODE_ROW;
            r_op     <= OP_MUL;
            r_last   <= 1'b0;
            r_any    <= 1'b0;
            r_digits <= '0;
            r_cnt    <= '0;
            r_pv     <= '0;
            r_acc    <= '0;
        end else begin
            if (w_ld_start) begin
                r_acc  <= '0;
                r_mode <= mode_t'(bus.mode);
            end
            if (w_take) begin
                r_digits <= bus.in_digits;
                r_op     <= op_t'(bus.in_op);
                r_last   <= bus.in_last;
                r_pv     <= (bus.in_op == OP_ADD) ? '0 : RES_W'(1);
                r_any    <= 1'b0;
                r_cnt    <= '0;
            end
            if (w_step) begin
                r_cnt <= r_cnt + CW'(1);
                if (w_nonblank) begin
                    r_pv  <= w_pv_next;
                    r_any <= 1'b1;
                end
            end
            if (w_commit) begin
                r_acc <= w_acc_next;
                r_cnt <= '0;
            end
        end
    end

    assign bus.in_ready = (r_state == WAIT_IN);
    assign bus.busy     = (r_state == WAIT_IN) || (r_state == TERM) ||
                          (r_state == COMMIT);
    assign bus.done     = (r_state == DONE);
    assign bus.result   = r_acc;

endmodule
